// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, flag bit positions and the multiply sequencer states.
package alu_pkg;

  localparam logic [3:0] ADD = 4'b0000;
  localparam logic [3:0] SUB = 4'b0001;
  localparam logic [3:0] IDT = 4'b1100;
  localparam logic [3:0] NON = 4'b1111;

  localparam int unsigned FLAG_S = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } mul_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// 16x16->32 unsigned shift-and-add multiplier that borrows the shared ALU for each add
// and hands the ALU to the external requester whenever no multiply is running.
module alu_mul_seq
  import alu_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [15:0] OPA,
  input  logic [15:0] OPB,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] PROD_HI,
  output logic [15:0] PROD_LO,
  output logic [15:0] ALU_A,
  output logic [15:0] ALU_B,
  output logic [3:0]  ALU_S,
  input  logic [15:0] ALU_Y,
  input  logic [3:0]  ALU_F,
  input  logic [15:0] EXT_A,
  input  logic [15:0] EXT_B,
  input  logic [3:0]  EXT_S,
  output logic        EXT_GNT,
  output logic [15:0] EXT_Y,
  output logic [3:0]  EXT_F
);

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 4;

  mul_state_e     state;
  logic [W-1:0]   mcand;
  logic [W-1:0]   acc;
  logic [W-1:0]   mq;
  logic [CW-1:0]  cnt;
  logic           busy_q;
  logic           done_q;
  logic           gnt_q;

  // State, datapath and registered status flags; status bits change together with the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      mcand  <= '0;
      acc    <= '0;
      mq     <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      gnt_q  <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE, FIN: begin
          if (START) begin
            mcand  <= OPA;
            mq     <= OPB;
            acc    <= '0;
            cnt    <= '0;
            state  <= RUN;
            busy_q <= 1'b1;
            gnt_q  <= 1'b0;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          // 33-bit right shift of {carry, sum, multiplier}: carry lands in acc[15]
          {acc, mq} <= {ALU_F[FLAG_C], ALU_Y, mq[W-1:1]};
          cnt       <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) begin
            state  <= FIN;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            gnt_q  <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          gnt_q  <= 1'b1;
        end
      endcase
    end
  end

  // ALU ownership mux: external requester whenever the sequencer is not iterating.
  always_comb begin
    ALU_A = EXT_A;
    ALU_B = EXT_B;
    ALU_S = EXT_S;
    if (!gnt_q) begin
      ALU_A = acc;
      ALU_B = mq[0] ? mcand : '0;
      ALU_S = ADD;
    end
  end

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign EXT_GNT = gnt_q;
  assign PROD_HI = acc;
  assign PROD_LO = mq;
  assign EXT_Y   = ALU_Y;
  assign EXT_F   = ALU_F;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq with a behavioural 16-bit ALU beside it.
module tb_alu_mul_seq;
  import alu_pkg::*;

  logic        CLK = 1'b0;
  logic        RST, START;
  logic [15:0] OPA, OPB;
  logic        BUSY, DONE;
  logic [15:0] PROD_HI, PROD_LO;
  logic [15:0] ALU_A, ALU_B, ALU_Y;
  logic [3:0]  ALU_S, ALU_F;
  logic [15:0] EXT_A, EXT_B, EXT_Y;
  logic [3:0]  EXT_S, EXT_F;
  logic        EXT_GNT;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  alu_mul_seq dut (
    .CLK(CLK), .RST(RST), .START(START), .OPA(OPA), .OPB(OPB),
    .BUSY(BUSY), .DONE(DONE), .PROD_HI(PROD_HI), .PROD_LO(PROD_LO),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_S(ALU_S), .ALU_Y(ALU_Y), .ALU_F(ALU_F),
    .EXT_A(EXT_A), .EXT_B(EXT_B), .EXT_S(EXT_S), .EXT_GNT(EXT_GNT),
    .EXT_Y(EXT_Y), .EXT_F(EXT_F)
  );

  // Behavioural ALU: flags {S,Z,C,V}
  logic [16:0] alu_sum;
  logic        alu_v;
  always_comb begin
    alu_v = 1'b0;
    case (ALU_S)
      ADD: begin
        alu_sum = {1'b0, ALU_A} + {1'b0, ALU_B};
        alu_v   = (ALU_A[15] == ALU_B[15]) && (alu_sum[15] != ALU_A[15]);
      end
      SUB: begin
        alu_sum = {1'b0, ALU_A} - {1'b0, ALU_B};
        alu_v   = (ALU_A[15] != ALU_B[15]) && (alu_sum[15] != ALU_A[15]);
      end
      IDT:     alu_sum = {1'b0, ALU_A};
      default: alu_sum = '0;
    endcase
    ALU_Y = alu_sum[15:0];
    ALU_F = {alu_sum[15], alu_sum[15:0] == 16'h0, alu_sum[16], alu_v};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts at a negedge; returns at the negedge where DONE is seen (or on timeout).
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                         output logic [31:0] p, output int lat, output int busy_n);
    OPA = a; OPB = b; START = 1'b1;
    lat = 0; busy_n = 0;
    @(posedge CLK); lat++;
    @(negedge CLK); START = 1'b0;
    if (BUSY) busy_n++;
    while (!DONE && lat < 40) begin
      @(posedge CLK); lat++;
      @(negedge CLK);
      if (BUSY) busy_n++;
    end
    p = {PROD_HI, PROD_LO};
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] p;
  int          lat, busy_n;

  initial begin
    vecs[0] = '{16'h0003, 16'h0005, 32'h0000_000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    vecs[2] = '{16'h1234, 16'h0000, 32'h0000_0000};
    vecs[3] = '{16'h0000, 16'hBEEF, 32'h0000_0000};
    vecs[4] = '{16'h8000, 16'h0002, 32'h0001_0000};
    vecs[5] = '{16'hFFFF, 16'h0001, 32'h0000_FFFF};

    RST = 1'b1; START = 1'b0; OPA = '0; OPB = '0;
    EXT_A = '0; EXT_B = '0; EXT_S = NON;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_busy", 32'(BUSY), 32'd0);
    chk("reset_done", 32'(DONE), 32'd0);
    chk("reset_prod", {PROD_HI, PROD_LO}, 32'd0);
    chk("reset_gnt", 32'(EXT_GNT), 32'd1);
    RST = 1'b0;

    // Idle passthrough
    EXT_A = 16'h7FFF; EXT_B = 16'h0001; EXT_S = ADD;
    #1;
    chk("pass_gnt", 32'(EXT_GNT), 32'd1);
    chk("pass_y", 32'(EXT_Y), 32'h8000);
    chk("pass_f", 32'(EXT_F), 32'b1001);
    @(negedge CLK);

    // Table vectors: product, latency, busy length, single-cycle DONE
    foreach (vecs[i]) begin
      run_mul(vecs[i].a, vecs[i].b, p, lat, busy_n);
      chk($sformatf("vec%0d_prod", i), p, vecs[i].p);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd17);
      chk($sformatf("vec%0d_busy", i), 32'(busy_n), 32'd16);
      @(negedge CLK);
      chk($sformatf("vec%0d_done_pulse", i), 32'(DONE), 32'd0);
      chk($sformatf("vec%0d_hold", i), {PROD_HI, PROD_LO}, vecs[i].p);
    end

    // Random vectors against plain multiplication
    for (int i = 0; i < 16; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      run_mul(a, b, p, lat, busy_n);
      chk($sformatf("rand%0d_prod", i), p, 32'(a) * 32'(b));
    end
    @(negedge CLK);

    // ALU ownership during RUN ignores the external select
    EXT_S = NON; EXT_A = 16'hAAAA;
    OPA = 16'h0011; OPB = 16'h0022; START = 1'b1;
    @(posedge CLK); @(negedge CLK); START = 1'b0;
    chk("run_gnt", 32'(EXT_GNT), 32'd0);
    chk("run_alu_s", 32'(ALU_S), 32'(ADD));
    chk("run_alu_a", 32'(ALU_A), 32'h0000);
    begin
      int n = 0;
      while (!DONE && n < 40) begin @(posedge CLK); n++; @(negedge CLK); end
      chk("run_prod", {PROD_HI, PROD_LO}, 32'h0000_0242);
      chk("fin_gnt", 32'(EXT_GNT), 32'd1);
      chk("fin_alu_a", 32'(ALU_A), 32'hAAAA);
    end
    @(negedge CLK);

    // START held high: one accept per 17 cycles
    begin
      int done_at[$];
      logic [31:0] done_p[$];
      int busy_cnt = 0;
      OPA = 16'h0002; OPB = 16'h0003; START = 1'b1;
      for (int e = 1; e <= 34; e++) begin
        @(posedge CLK); @(negedge CLK);
        if (BUSY) busy_cnt++;
        if (DONE) begin done_at.push_back(e); done_p.push_back({PROD_HI, PROD_LO}); end
      end
      START = 1'b0;
      chk("b2b_count", 32'(done_at.size()), 32'd2);
      chk("b2b_busy", 32'(busy_cnt), 32'd32);
      if (done_at.size() == 2) begin
        chk("b2b_t0", 32'(done_at[0]), 32'd17);
        chk("b2b_t1", 32'(done_at[1]), 32'd34);
        chk("b2b_p0", done_p[0], 32'd6);
        chk("b2b_p1", done_p[1], 32'd6);
      end
      @(posedge CLK); @(negedge CLK);
      chk("b2b_idle", 32'(BUSY), 32'd0);
    end

    // Reset mid-run aborts without DONE
    OPA = 16'h1234; OPB = 16'h5678; START = 1'b1;
    @(posedge CLK); @(negedge CLK); START = 1'b0;
    repeat (8) begin @(posedge CLK); @(negedge CLK); end
    RST = 1'b1; START = 1'b1;
    @(posedge CLK); @(negedge CLK);
    RST = 1'b0; START = 1'b0;
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_prod", {PROD_HI, PROD_LO}, 32'd0);
    chk("abort_gnt", 32'(EXT_GNT), 32'd1);
    begin
      int seen = 0;
      for (int e = 0; e < 20; e++) begin
        @(posedge CLK); @(negedge CLK);
        if (DONE || BUSY) seen++;
      end
      chk("abort_quiet", 32'(seen), 32'd0);
    end
    run_mul(16'h0007, 16'h0009, p, lat, busy_n);
    chk("after_abort_prod", p, 32'h0000_003F);
    chk("after_abort_lat", 32'(lat), 32'd17);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
